// File: rtl/dm_responder.sv
// Data-memory responder for the multi-cycle datapath. It accepts one word
// request at a time, waits a fixed latency, then performs the access and pulses ack.
module dm_responder #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        be,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              err,
   output logic              busy,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int         DEPTH   = 1 << ADDR_W;
   localparam logic [3:0] LAT_CNT = 4'(LATENCY);

   // Handshake: the requester raises req with we/addr/wdata/be and holds req until
   // it sees ack. A request is taken only in IDLE; the fields are copied on that edge
   // and later input changes are ignored. ack is a one-cycle pulse, err and rdata are
   // meaningful with it, and req is ignored during the ack cycle.

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [31:0]         addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          be_q, be_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                do_access;
   logic                we_eff;
   logic [31:0]         addr_eff;
   logic [DATA_W-1:0]   wdata_eff;
   logic [3:0]          be_eff;
   logic [ADDR_W-1:0]   mem_idx;
   logic                fault;
   logic                mem_we;
   logic [DATA_W-1:0]   mem_rdata;

   // With zero latency the access happens on the capture edge, so it must see the
   // live inputs rather than the captured copy.
   always_comb begin
      we_eff    = we_q;
      addr_eff  = addr_q;
      wdata_eff = wdata_q;
      be_eff    = be_q;
      if (state_q == IDLE) begin
         we_eff    = we;
         addr_eff  = addr;
         wdata_eff = wdata;
         be_eff    = be;
      end
      mem_idx   = addr_eff[ADDR_W+1:2];
      fault     = (addr_eff[1:0] != 2'b00) || ((addr_eff >> (ADDR_W + 2)) != 32'd0);
      mem_rdata = mem[mem_idx];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      do_access = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               be_d    = be;
               cnt_d   = LAT_CNT;
               if (LATENCY == 0) begin
                  state_d   = ACK;
                  do_access = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d   = ACK;
               do_access = 1'b1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (do_access) begin
         ack_d = 1'b1;
         if (fault) begin
            err_d   = 1'b1;
            rdata_d = '0;
         end else if (!we_eff) begin
            rdata_d = mem_rdata;
         end
      end
      mem_we = do_access && we_eff && !fault;
   end

   // The array sits in the reset block only so that no write can land while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
               if (be_eff[i]) mem[mem_idx][8*i +: 8] <= wdata_eff[8*i +: 8];
            end
         end
      end
   end

   assign rdata     = rdata_q;
   assign ack       = ack_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule
